// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS datapath and its controller.
package mc_pkg;

  typedef enum logic [1:0] {
    ALU_ADD     = 2'b00,
    ALU_SUB     = 2'b01,
    ALU_FUNCT   = 2'b10,
    ALU_ADD_ALT = 2'b11
  } alu_op_e;

  // Operation actually performed by the ALU after funct decode.
  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt
  } alu_ctrl_e;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_HOLD   = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

endpackage

// File: rtl/mc_regfile.sv
// 32-entry register file: two combinational read ports, one synchronous write port, r0 == 0.
module mc_regfile #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       raddr_a,
  input  logic [4:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             we,
  input  logic [4:0]       waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0)) begin
      regs_d[waddr] = wdata;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads see the pre-edge contents, so same-edge A/B captures get the old value.
  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/multicycle_datapath.sv
// MIPS multicycle datapath: PC, IR, MDR, A, B, ALUOut, regfile and ALU, sequenced externally.
module multicycle_datapath
  import mc_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             IorD,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             IRWrite,
  input  logic             MemToReg,
  input  logic             ALUSrcA,
  input  logic             RegWrite,
  input  logic             RegDst,
  input  logic [1:0]       PCSource,
  input  logic [1:0]       ALUOp,
  input  logic [1:0]       ALUSrcB,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [5:0]       opcode,
  output logic             zero,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_re,
  output logic             mem_we,
  output logic [WIDTH-1:0] pc_out
);

  logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d;
  logic [WIDTH-1:0] mdr_q, a_q, b_q, alu_out_q;
  logic [WIDTH-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic [4:0]       rf_waddr;
  logic [WIDTH-1:0] imm_sext, alu_a, alu_b, alu_result, pc_next;
  alu_ctrl_e        alu_ctrl;
  logic             pc_we;
  logic             unused_shamt;

  assign unused_shamt = ^ir_q[10:6];

  assign rf_waddr = RegDst ? ir_q[15:11] : ir_q[20:16];
  assign rf_wdata = MemToReg ? mdr_q : alu_out_q;

  mc_regfile #(
    .WIDTH(WIDTH)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr_a(ir_q[25:21]),
    .raddr_b(ir_q[20:16]),
    .rdata_a(rf_rdata_a),
    .rdata_b(rf_rdata_b),
    .we     (RegWrite),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata)
  );

  always_comb begin
    imm_sext = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
    alu_a    = ALUSrcA ? a_q : pc_q;
    alu_b    = b_q;
    case (ALUSrcB)
      SRCB_REG:  alu_b = b_q;
      SRCB_FOUR: alu_b = WIDTH'(4);
      SRCB_IMM:  alu_b = imm_sext;
      default:   alu_b = imm_sext << 2;
    endcase
  end

  always_comb begin
    alu_ctrl = AluAdd;
    case (alu_op_e'(ALUOp))
      ALU_SUB: alu_ctrl = AluSub;
      ALU_FUNCT: begin
        case (ir_q[5:0])
          FUNCT_SUB: alu_ctrl = AluSub;
          FUNCT_AND: alu_ctrl = AluAnd;
          FUNCT_OR:  alu_ctrl = AluOr;
          FUNCT_SLT: alu_ctrl = AluSlt;
          default:   alu_ctrl = AluAdd;
        endcase
      end
      default: alu_ctrl = AluAdd;
    endcase
  end

  always_comb begin
    alu_result = alu_a + alu_b;
    case (alu_ctrl)
      AluSub:  alu_result = alu_a - alu_b;
      AluAnd:  alu_result = alu_a & alu_b;
      AluOr:   alu_result = alu_a | alu_b;
      AluSlt:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = alu_a + alu_b;
    endcase
  end

  // Held low in reset so the controller never sees a spurious branch-taken.
  assign zero = ~reset & (alu_result == '0);

  always_comb begin
    pc_next = pc_q;
    case (PCSource)
      PCSRC_ALU:    pc_next = alu_result;
      PCSRC_ALUOUT: pc_next = alu_out_q;
      PCSRC_JUMP:   pc_next = {pc_q[WIDTH-1:28], ir_q[25:0], 2'b00};
      default:      pc_next = pc_q;
    endcase
    pc_we = PCWrite | (PCWriteCond & zero);
    pc_d  = pc_we ? pc_next : pc_q;
    ir_d  = IRWrite ? mem_rdata : ir_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mem_rdata;
      a_q       <= rf_rdata_a;
      b_q       <= rf_rdata_b;
      alu_out_q <= alu_result;
    end
  end

  assign opcode    = ir_q[31:26];
  assign mem_addr  = IorD ? alu_out_q : pc_q;
  assign mem_wdata = b_q;
  assign mem_re    = MemRead;
  assign mem_we    = MemWrite;
  assign pc_out    = pc_q;

  mem_rw_exclusive_a: assert property (@(posedge clk) disable iff (reset)
    !(MemRead && MemWrite));

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: ALU vector table plus lw/beq/jump/reset sequences.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg;
  logic        ALUSrcA, RegWrite, RegDst;
  logic [1:0]  PCSource, ALUOp, ALUSrcB;
  logic [31:0] mem_rdata;
  logic [5:0]  opcode;
  logic        zero;
  logic [31:0] mem_addr, mem_wdata, pc_out;
  logic        mem_re, mem_we;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_datapath #(
    .WIDTH   (32),
    .PC_RESET(32'h0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemToReg   (MemToReg),
    .ALUSrcA    (ALUSrcA),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .PCSource   (PCSource),
    .ALUOp      (ALUOp),
    .ALUSrcB    (ALUSrcB),
    .mem_rdata  (mem_rdata),
    .opcode     (opcode),
    .zero       (zero),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .pc_out     (pc_out)
  );

  typedef struct {
    string       name;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    PCWrite = 0; PCWriteCond = 0; IorD = 0; MemRead = 0; MemWrite = 0; IRWrite = 0;
    MemToReg = 0; ALUSrcA = 0; RegWrite = 0; RegDst = 0;
    PCSource = 2'b00; ALUOp = 2'b00; ALUSrcB = 2'b00;
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
    tick();
  endtask

  // Latch an instruction into IR, then one more edge so A/B reflect its rs/rt.
  task automatic load_ir(input logic [31:0] word);
    idle();
    mem_rdata = word;
    IRWrite   = 1;
    tick();
    IRWrite   = 0;
    mem_rdata = 32'h0;
    tick();
  endtask

  // Route a value through MDR into register r.
  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    idle();
    mem_rdata = {6'b100011, 5'd0, r, 16'd0};
    IRWrite   = 1;
    tick();
    IRWrite   = 0;
    mem_rdata = v;
    tick();
    RegWrite  = 1;
    MemToReg  = 1;
    tick();
    idle();
    mem_rdata = 32'h0;
  endtask

  // Leaves register r in B (visible on mem_wdata) and opcode = lw.
  task automatic read_b(input logic [4:0] r);
    load_ir({6'b100011, 5'd0, r, 16'd0});
  endtask

  initial begin
    vecs[0] = '{"add",      2'b10, 6'b100000, 32'd5,        32'd7,        32'd12,       1'b0};
    vecs[1] = '{"slt_neg",  2'b10, 6'b101010, 32'hFFFFFFFF, 32'd7,        32'd1,        1'b0};
    vecs[2] = '{"slt_pos",  2'b10, 6'b101010, 32'd7,        32'hFFFFFFFF, 32'd0,        1'b1};
    vecs[3] = '{"sub_eq",   2'b10, 6'b100010, 32'd9,        32'd9,        32'd0,        1'b1};
    vecs[4] = '{"and",      2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[5] = '{"or",       2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
    vecs[6] = '{"bad_fn",   2'b10, 6'b000000, 32'd3,        32'd4,        32'd7,        1'b0};
    vecs[7] = '{"op_sub",   2'b01, 6'b100000, 32'd3,        32'd4,        32'hFFFFFFFF, 1'b0};
    vecs[8] = '{"op11_wrap",2'b11, 6'b100010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
    vecs[9] = '{"op00_add", 2'b00, 6'b100010, 32'd10,       32'd20,       32'd30,       1'b0};

    idle();
    mem_rdata = 32'h0;
    reset = 1;
    #1;
    check("rst_pc", pc_out, 32'h0);
    check("rst_opcode", {26'd0, opcode}, 32'h0);
    check("rst_zero", {31'd0, zero}, 32'h0);
    check("rst_b", mem_wdata, 32'h0);
    tick();
    tick();
    reset = 0;
    tick();

    // Fetch of lw $2,4($1) with reg1 = 0x10.
    write_reg(5'd1, 32'h10);
    check("fetch_addr", mem_addr, 32'h0);
    mem_rdata = 32'h8C220004;
    IRWrite = 1; PCWrite = 1; ALUSrcA = 0; ALUSrcB = 2'b01; ALUOp = 2'b00; PCSource = 2'b00;
    tick();
    check("fetch_opcode", {26'd0, opcode}, 32'h23);
    check("fetch_pc", pc_out, 32'h4);

    // Decode, address calc, memory read, writeback.
    idle();
    mem_rdata = 32'h0;
    ALUSrcB = 2'b11;
    tick();
    idle();
    ALUSrcA = 1; ALUSrcB = 2'b10;
    tick();
    IorD = 1;
    #1;
    check("lw_addr", mem_addr, 32'h14);
    MemRead = 1;
    mem_rdata = 32'hDEADBEEF;
    #1;
    check("lw_mem_re", {31'd0, mem_re}, 32'h1);
    check("lw_mem_we", {31'd0, mem_we}, 32'h0);
    tick();
    idle();
    mem_rdata = 32'h0;
    RegWrite = 1; MemToReg = 1;
    tick();
    read_b(5'd2);
    check("lw_reg2", mem_wdata, 32'hDEADBEEF);

    // Asynchronous reset mid-run with a register write pending.
    idle();
    RegWrite = 1; MemToReg = 1; mem_rdata = 32'h12345678;
    tick();
    #2;
    reset = 1;
    #1;
    check("midrst_pc", pc_out, 32'h0);
    check("midrst_opcode", {26'd0, opcode}, 32'h0);
    check("midrst_b", mem_wdata, 32'h0);
    check("midrst_zero", {31'd0, zero}, 32'h0);
    tick();
    idle();
    mem_rdata = 32'h0;
    reset = 0;
    tick();
    read_b(5'd2);
    check("midrst_reg2", mem_wdata, 32'h0);
    read_b(5'd1);
    check("midrst_reg1", mem_wdata, 32'h0);

    // ALU vector table: reg1 = a, reg2 = b, R-type writes reg3.
    for (int i = 0; i < 10; i++) begin
      write_reg(5'd1, vecs[i].a);
      write_reg(5'd2, vecs[i].b);
      load_ir({6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, vecs[i].funct});
      ALUSrcA = 1; ALUSrcB = 2'b00; ALUOp = vecs[i].aluop;
      #1;
      check({vecs[i].name, "_zero"}, {31'd0, zero}, {31'd0, vecs[i].exp_zero});
      tick();
      RegDst = 1; RegWrite = 1;
      tick();
      read_b(5'd3);
      check({vecs[i].name, "_reg3"}, mem_wdata, vecs[i].exp);
    end

    // beq taken: ALUOut = PC + (0x10 << 2) = 0x40.
    pulse_reset();
    write_reg(5'd1, 32'd9);
    write_reg(5'd2, 32'd9);
    load_ir({6'b000100, 5'd1, 5'd2, 16'h0010});
    ALUSrcA = 0; ALUSrcB = 2'b11;
    tick();
    idle();
    ALUSrcA = 1; ALUSrcB = 2'b00; ALUOp = 2'b01; PCWriteCond = 1; PCSource = 2'b01;
    #1;
    check("beq_zero", {31'd0, zero}, 32'h1);
    tick();
    check("beq_pc", pc_out, 32'h40);

    // beq not taken.
    write_reg(5'd2, 32'd8);
    load_ir({6'b000100, 5'd1, 5'd2, 16'h0010});
    ALUSrcA = 0; ALUSrcB = 2'b11;
    tick();
    idle();
    ALUSrcA = 1; ALUSrcB = 2'b00; ALUOp = 2'b01; PCWriteCond = 1; PCSource = 2'b01;
    #1;
    check("bne_zero", {31'd0, zero}, 32'h0);
    tick();
    check("bne_pc", pc_out, 32'h40);

    // PCWrite and PCWriteCond together: single write of alu_result 9-8.
    idle();
    ALUSrcA = 1; ALUOp = 2'b01; PCWrite = 1; PCWriteCond = 1; PCSource = 2'b00;
    tick();
    check("both_pc", pc_out, 32'h1);

    // Jump keeps PC[31:28].
    write_reg(5'd1, 32'h30000004);
    load_ir({6'b000000, 5'd1, 5'd0, 16'h0000});
    ALUSrcA = 1; ALUSrcB = 2'b10; ALUOp = 2'b00; PCSource = 2'b00; PCWrite = 1;
    tick();
    check("set_pc", pc_out, 32'h30000004);
    load_ir({6'b000010, 26'h0000010});
    check("j_opcode", {26'd0, opcode}, 32'h2);
    PCSource = 2'b10; PCWrite = 1;
    tick();
    check("j_pc", pc_out, 32'h30000040);
    PCSource = 2'b11;
    tick();
    check("hold_pc", pc_out, 32'h30000040);

    // Register 0 ignores writes.
    write_reg(5'd0, 32'h0000FFFF);
    read_b(5'd0);
    check("reg0", mem_wdata, 32'h0);

    // Store strobes pass through, B drives write data.
    write_reg(5'd5, 32'hCAFEF00D);
    read_b(5'd5);
    MemWrite = 1;
    #1;
    check("sw_we", {31'd0, mem_we}, 32'h1);
    check("sw_re", {31'd0, mem_re}, 32'h0);
    check("sw_wdata", mem_wdata, 32'hCAFEF00D);
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
